// File: rtl/multi_phase_signal_controller.sv
// Multi-phase round-robin signal controller with an internal countdown timer.
// Serves NUM_PHASES approaches in rotation, skips approaches without demand,
// inserts an exclusive all-walk phase on a latched pedestrian request, and
// separates every phase with an all-red clearance interval.
module multi_phase_signal_controller #(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W    = 8,
  parameter int GREEN_T    = 10,
  parameter int YELLOW_T   = 5,
  parameter int ALLRED_T   = 1,
  parameter int PED_T      = 15,
  parameter int PHASE_W    = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [NUM_PHASES-1:0]   car_req,
  input  logic                    ped,
  output logic [3*NUM_PHASES-1:0] light,
  output logic [NUM_PHASES-1:0]   walk,
  output logic [PHASE_W-1:0]      active_phase,
  output logic                    busy_ped
);

  // Duration bounds: every state must last at least one tick and its
  // duration must fit in the countdown timer.
  localparam longint MAX_DUR = (64'd1 << TIMER_W) - 1;

  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
    $error("NUM_PHASES must be in the range 2..8");
  end
  if (GREEN_T < 1 || longint'(GREEN_T) > MAX_DUR ||
      YELLOW_T < 1 || longint'(YELLOW_T) > MAX_DUR ||
      ALLRED_T < 1 || longint'(ALLRED_T) > MAX_DUR ||
      PED_T < 1 || longint'(PED_T) > MAX_DUR) begin : g_bad_duration
    $error("All durations must be >= 1 and < 2**TIMER_W");
  end

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_PED
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_T);
  localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T);
  localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_T);
  localparam logic [TIMER_W-1:0] PED_LD    = TIMER_W'(PED_T);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_e                    state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [PHASE_W-1:0]        active_q, active_d;
  logic                      pend_q, pend_d;
  logic [3*NUM_PHASES-1:0]   light_q, light_d;
  logic [NUM_PHASES-1:0]     walk_q, walk_d;
  logic                      busy_q, busy_d;

  // First requesting approach after cur (wrapping); free rotation when idle.
  function automatic logic [PHASE_W-1:0] select_phase(
    input logic [PHASE_W-1:0]    cur,
    input logic [NUM_PHASES-1:0] req
  );
    logic [PHASE_W-1:0] sel;
    logic               found;
    int                 idx;
    sel   = PHASE_W'((int'(cur) + 1) % NUM_PHASES);
    found = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      idx = (int'(cur) + k) % NUM_PHASES;
      if (!found && req[idx]) begin
        sel   = PHASE_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Next-state logic: timer countdown, state exits, phase select, ped latch.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
    pend_d   = pend_q;

    // Requests made during the walk phase are ignored so a held button does
    // not produce back-to-back walk phases.
    if (ped && state_q != S_PED) begin
      pend_d = 1'b1;
    end

    if (tick) begin
      if (timer_q == TIMER_ONE) begin
        unique case (state_q)
          S_GREEN: begin
            state_d = S_YELLOW;
            timer_d = YELLOW_LD;
          end
          S_YELLOW, S_PED: begin
            state_d = S_ALL_RED;
            timer_d = ALLRED_LD;
          end
          S_ALL_RED: begin
            // Decision uses the registered latch only: a press on this very
            // cycle is latched and served after the next green.
            if (pend_q) begin
              state_d = S_PED;
              timer_d = PED_LD;
              pend_d  = 1'b0;
            end else begin
              state_d  = S_GREEN;
              timer_d  = GREEN_LD;
              active_d = select_phase(active_q, car_req);
            end
          end
        endcase
      end else begin
        timer_d = timer_q - TIMER_ONE;
      end
    end
  end

  // Lamp decode from the next state so the outputs are registered alongside it.
  always_comb begin
    light_d = {NUM_PHASES{LAMP_RED}};
    walk_d  = '0;
    unique case (state_d)
      S_GREEN: begin
        light_d[3*int'(active_d) +: 3] = LAMP_GREEN;
        walk_d[active_d]               = 1'b1;
      end
      S_YELLOW: begin
        light_d[3*int'(active_d) +: 3] = LAMP_YELLOW;
        walk_d[active_d]               = 1'b1;
      end
      S_PED: begin
        walk_d = '1;
      end
      S_ALL_RED: begin
        walk_d = '0;
      end
    endcase
    busy_d = pend_d | (state_d == S_PED);
  end

  // State, timer, phase, pedestrian latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= S_ALL_RED;
      timer_q  <= ALLRED_LD;
      active_q <= LAST_PHASE;
      pend_q   <= 1'b0;
      light_q  <= {NUM_PHASES{LAMP_RED}};
      walk_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      light_q  <= light_d;
      walk_q   <= walk_d;
      busy_q   <= busy_d;
    end
  end

  assign light        = light_q;
  assign walk         = walk_q;
  assign active_phase = active_q;
  assign busy_ped     = busy_q;

endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Self-checking bench for multi_phase_signal_controller: a directed vector
// table from reset, hand-written multi-cycle corner cases, and randomized
// stimulus compared against a behavioural segment-schedule model.
module tb_multi_phase_signal_controller;

  localparam int NP  = 4;
  localparam int G_T = 3;
  localparam int Y_T = 2;
  localparam int A_T = 1;
  localparam int P_T = 4;

  logic          clk;
  logic          rst;
  logic          tick;
  logic [NP-1:0] car_req;
  logic          ped;
  logic [3*NP-1:0] light;
  logic [NP-1:0] walk;
  logic [1:0]    active_phase;
  logic          busy_ped;

  int n_checks = 0;
  int n_errors = 0;

  multi_phase_signal_controller #(
    .NUM_PHASES(NP),
    .TIMER_W   (8),
    .GREEN_T   (G_T),
    .YELLOW_T  (Y_T),
    .ALLRED_T  (A_T),
    .PED_T     (P_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .car_req     (car_req),
    .ped         (ped),
    .light       (light),
    .walk        (walk),
    .active_phase(active_phase),
    .busy_ped    (busy_ped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: a schedule of timed segments ----------
  typedef enum int {M_CLEAR, M_GO, M_CAUTION, M_WALK} seg_e;
  seg_e m_seg;
  int   m_left;
  int   m_phase;
  bit   m_pend;

  task automatic model_reset();
    m_seg   = M_CLEAR;
    m_left  = A_T;
    m_phase = NP - 1;
    m_pend  = 1'b0;
  endtask

  function automatic int pick_phase(input logic [NP-1:0] req);
    for (int k = 1; k <= NP; k++) begin
      if (req[(m_phase + k) % NP]) return (m_phase + k) % NP;
    end
    return (m_phase + 1) % NP;
  endfunction

  task automatic model_step(input logic t, input logic [NP-1:0] req, input logic p);
    bit next_pend;
    next_pend = m_pend;
    if (p && m_seg != M_WALK) next_pend = 1'b1;
    if (t) begin
      if (m_left > 1) begin
        m_left = m_left - 1;
      end else begin
        case (m_seg)
          M_GO:      begin m_seg = M_CAUTION; m_left = Y_T; end
          M_CAUTION: begin m_seg = M_CLEAR;   m_left = A_T; end
          M_WALK:    begin m_seg = M_CLEAR;   m_left = A_T; end
          default: begin
            if (m_pend) begin
              m_seg = M_WALK; m_left = P_T; next_pend = 1'b0;
            end else begin
              m_phase = pick_phase(req); m_seg = M_GO; m_left = G_T;
            end
          end
        endcase
      end
    end
    m_pend = next_pend;
  endtask

  function automatic logic [3*NP-1:0] m_light();
    logic [3*NP-1:0] l;
    for (int i = 0; i < NP; i++) begin
      l[3*i +: 3] = 3'b001;
      if (i == m_phase && m_seg == M_GO)      l[3*i +: 3] = 3'b100;
      if (i == m_phase && m_seg == M_CAUTION) l[3*i +: 3] = 3'b010;
    end
    return l;
  endfunction

  function automatic logic [NP-1:0] m_walk();
    if (m_seg == M_WALK) return '1;
    if (m_seg == M_GO || m_seg == M_CAUTION) return NP'(1) << m_phase;
    return '0;
  endfunction

  // ---------------- checking helpers -----------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".light"},  32'(light),        32'(m_light()));
    check({tag, ".walk"},   32'(walk),         32'(m_walk()));
    check({tag, ".active"}, 32'(active_phase), 32'(m_phase));
    check({tag, ".busy"},   32'(busy_ped),     32'(m_pend || m_seg == M_WALK));
  endtask

  // Called at a negedge: drive, advance one clock, sample at the next negedge.
  task automatic cycle(input logic t, input logic [NP-1:0] c, input logic p, input bit chk,
                       input string tag);
    tick = t; car_req = c; ped = p;
    @(posedge clk);
    model_step(t, c, p);
    @(negedge clk);
    if (chk) compare_model(tag);
  endtask

  // ---------------- directed vector table ------------------------------------
  typedef struct {
    logic          t;
    logic [NP-1:0] car;
    logic          p;
    logic [3*NP-1:0] exp_light;
    logic [NP-1:0] exp_walk;
    logic [1:0]    exp_act;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [18];

  int green_cnt [NP];
  int ped_cycles;
  int green_cycles;
  bit found;

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 12'h24C, 4'h1, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 1'b0, 12'h24C, 4'h1, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 1'b0, 12'h24C, 4'h1, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 1'b0, 12'h24A, 4'h1, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 1'b0, 12'h24A, 4'h1, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 1'b0, 12'h249, 4'h0, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 1'b0, 12'h261, 4'h2, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, 1'b1, 12'h261, 4'h2, 2'd1, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 1'b0, 12'h261, 4'h2, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 4'h0, 1'b0, 12'h251, 4'h2, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 12'h251, 4'h2, 2'd1, 1'b1};
    vecs[11] = '{1'b1, 4'h0, 1'b0, 12'h249, 4'h0, 2'd1, 1'b1};
    vecs[12] = '{1'b1, 4'h0, 1'b0, 12'h249, 4'hF, 2'd1, 1'b1};
    vecs[13] = '{1'b1, 4'h0, 1'b0, 12'h249, 4'hF, 2'd1, 1'b1};
    vecs[14] = '{1'b1, 4'h0, 1'b0, 12'h249, 4'hF, 2'd1, 1'b1};
    vecs[15] = '{1'b1, 4'h0, 1'b0, 12'h249, 4'hF, 2'd1, 1'b1};
    vecs[16] = '{1'b1, 4'h0, 1'b0, 12'h249, 4'h0, 2'd1, 1'b0};
    vecs[17] = '{1'b1, 4'h0, 1'b0, 12'h309, 4'h4, 2'd2, 1'b0};

    // Reset state
    rst = 1'b1; tick = 1'b0; car_req = '0; ped = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    check("reset.light",  32'(light),        32'h249);
    check("reset.walk",   32'(walk),         32'h0);
    check("reset.active", 32'(active_phase), 32'd3);
    check("reset.busy",   32'(busy_ped),     32'd0);
    rst = 1'b0;

    // Rotation from reset, then a ped pulse and the exclusive walk phase
    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].t, vecs[i].car, vecs[i].p, 1'b0, "vec");
      check($sformatf("vec%0d.light", i),  32'(light),        32'(vecs[i].exp_light));
      check($sformatf("vec%0d.walk", i),   32'(walk),         32'(vecs[i].exp_walk));
      check($sformatf("vec%0d.active", i), 32'(active_phase), 32'(vecs[i].exp_act));
      check($sformatf("vec%0d.busy", i),   32'(busy_ped),     32'(vecs[i].exp_busy));
    end

    // tick held low mid-yellow freezes everything; one yellow tick remains
    cycle(1'b1, 4'h0, 1'b0, 1'b1, "frz_g");
    cycle(1'b1, 4'h0, 1'b0, 1'b1, "frz_g");
    cycle(1'b1, 4'h0, 1'b0, 1'b1, "frz_y");
    check("freeze.enter_yellow", 32'(light), 32'h289);
    cycle(1'b1, 4'h0, 1'b0, 1'b1, "frz_y");
    for (int i = 0; i < 50; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1, "frz_hold");
    check("freeze.held_light", 32'(light), 32'h289);
    check("freeze.held_walk",  32'(walk),  32'h4);
    cycle(1'b1, 4'h0, 1'b0, 1'b1, "frz_resume");
    check("freeze.resume_allred", 32'(light), 32'h249);

    // Only approach 3 has demand: it is the only one ever served
    for (int i = 0; i < NP; i++) green_cnt[i] = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(1'b1, 4'b1000, 1'b0, 1'b1, "solo3");
      for (int j = 0; j < NP; j++) if (light[3*j +: 3] == 3'b100) green_cnt[j]++;
    end
    check("solo3.green3_cycles", 32'(green_cnt[3]), 32'd18);
    check("solo3.other_greens",  32'(green_cnt[0] + green_cnt[1] + green_cnt[2]), 32'd0);
    check("solo3.active",        32'(active_phase), 32'd3);

    // Demand on 0 and 2: service alternates, 1 and 3 are skipped
    for (int i = 0; i < NP; i++) green_cnt[i] = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(1'b1, 4'b0101, 1'b0, 1'b1, "alt02");
      for (int j = 0; j < NP; j++) if (light[3*j +: 3] == 3'b100) green_cnt[j]++;
    end
    check("alt02.green0_cycles", 32'(green_cnt[0]), 32'd9);
    check("alt02.green2_cycles", 32'(green_cnt[2]), 32'd9);
    check("alt02.skipped",       32'(green_cnt[1] + green_cnt[3]), 32'd0);

    // Held ped: exactly one walk phase per green, never back-to-back
    ped_cycles = 0; green_cycles = 0;
    for (int i = 0; i < 44; i++) begin
      cycle(1'b1, 4'h0, 1'b1, 1'b1, "pedhold");
      if (walk == 4'hF) ped_cycles++;
      if (light != 12'h249 && light[3*int'(active_phase) +: 3] == 3'b100) green_cycles++;
    end
    check("pedhold.walk_cycles",  32'(ped_cycles),   32'd16);
    check("pedhold.green_cycles", 32'(green_cycles), 32'd12);

    // Async reset mid-green of phase 2 with a pending ped request
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 4'b0100, 1'b0, 1'b1, "seek2");
      if (light[8:6] == 3'b100) found = 1'b1;
    end
    check("seek2.found_green2", 32'(found), 32'd1);
    cycle(1'b1, 4'b0100, 1'b1, 1'b1, "rst_pend");
    check("rst_pend.busy_before", 32'(busy_ped), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst.light",  32'(light),        32'h249);
    check("async_rst.walk",   32'(walk),         32'h0);
    check("async_rst.busy",   32'(busy_ped),     32'd0);
    check("async_rst.active", 32'(active_phase), 32'd3);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'h0, 1'b0, 1'b1, "post_rst");
    check("post_rst.first_green", 32'(light),        32'h24C);
    check("post_rst.active",      32'(active_phase), 32'd0);

    // Randomized stimulus against the model
    car_req = '0;
    for (int i = 0; i < 1500; i++) begin
      logic          t;
      logic          p;
      logic [NP-1:0] c;
      t = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 19) == 0);
      c = car_req;
      if ($urandom_range(0, 7) == 0) c = NP'($urandom_range(0, 15));
      cycle(t, c, p, 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_phase_signal_controller.md
Name: multi_phase_signal_controller

Overview:
- Parametrised successor to the two-way intersection controller: serves NUM_PHASES approaches round-robin, with an internal countdown timer, so no external timer block is needed.
- Green phases skip approaches with no demand; a latched pedestrian request inserts an exclusive all-walk phase.
- An all-red clearance interval separates every phase.
- Sits between the sensor/button synchronisers and the lamp drivers; `tick` comes from the system time-base divider.

Parameters:
NUM_PHASES, 4, number of approaches (2..8)
TIMER_W, 8, countdown timer width
GREEN_T, 10, green duration in ticks
YELLOW_T, 5, yellow duration in ticks
ALLRED_T, 1, all-red clearance duration in ticks
PED_T, 15, exclusive pedestrian phase duration in ticks
PHASE_W, $clog2(NUM_PHASES), width of the phase index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  one-cycle time-base enable; timer advances only when high
car_req  in  NUM_PHASES  per-approach vehicle demand, level, bit i = phase i
ped  in  1  pedestrian button, pulse or level
light  out  3*NUM_PHASES  per-phase lamp, bits [3i+2:3i]; RED=001, YELLOW=010, GREEN=100
walk  out  NUM_PHASES  per-phase walk indication
active_phase  out  PHASE_W  index of phase last/currently served
busy_ped  out  1  high while ped_pending or in the PED state

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- States: ALL_RED, GREEN, YELLOW, PED. The encoding is internal.
- Outputs are Moore-decoded from registered state, so they change in the cycle after the transition edge.
- Reset values:
  - state=ALL_RED, timer=ALLRED_T, active_phase=NUM_PHASES-1, ped_pending=0.
  - light = all RED, walk=0, busy_ped=0.
- Timer:
  - Loaded with the duration of the state being entered, on the entering edge.
  - On each cycle with tick=1: if timer==1, take the state exit; else timer decrements.
  - With tick=0 the timer holds.
  - Each state therefore lasts exactly DUR ticks.
  - All durations are >=1 and <2^TIMER_W; this is checked by an elaboration-time assertion.
- Transitions (only on an exiting tick):
  - GREEN -> YELLOW.
  - YELLOW -> ALL_RED.
  - PED -> ALL_RED.
  - ALL_RED: if ped_pending -> PED; else -> GREEN on the selected phase.
- Phase select, evaluated combinationally on the ALL_RED exit cycle:
  - Search for the first set bit of car_req, starting at (active_phase+1) mod NUM_PHASES and wrapping.
  - If car_req==0, select (active_phase+1) mod NUM_PHASES (free rotation).
  - active_phase updates on GREEN entry.
- Lamps per state:
  - GREEN: phase active_phase = GREEN, others RED; walk bit active_phase = 1.
  - YELLOW: phase active_phase = YELLOW, others RED; walk bit active_phase = 1.
  - ALL_RED: all RED, walk=0.
  - PED: all RED, walk = all ones.
- Pedestrian latch:
  - ped_pending sets on any cycle with ped=1, except while in PED.
  - It clears on PED entry.
  - ped asserted in PED is ignored, so a held button does not cause back-to-back PED phases.
  - After PED exit, a held ped re-latches on the next cycle.
- Simultaneous events: ped on the same cycle as the ALL_RED exit is not seen by that exit decision. It is latched and served after the next phase.
- car_req changes mid-GREEN have no effect; there is no extension or early termination.
- Reset mid-operation: everything returns asynchronously to the reset values, and the sequence restarts with ALL_RED.

Test Plan:
Use NUM_PHASES=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, PED_T=4, and tick=1 every cycle unless stated.
1. Release rst, car_req=0, ped=0 -> ALL_RED 1 cycle, phase0 G 3 cycles, Y 2 cycles, AR 1 cycle, then phase1. Order is 0,1,2,3,0; period 24 cycles; light and walk match each state.
2. car_req=4'b1000 held -> only phase 3 ever turns GREEN; pattern AR1 G3 Y2 repeating; active_phase stays 3.
3. car_req=4'b0101, starting with active_phase=0 -> next GREEN is phase 2, then phase 0, alternating; phases 1 and 3 are never GREEN.
4. One-cycle ped pulse during phase0 GREEN -> busy_ped=1; after Y2 and AR1, PED lasts 4 cycles with walk=4'b1111 and light all RED; then AR1 and phase1 GREEN. A ped held through PED yields exactly one PED per cycle round.
5. tick=0 for 50 cycles mid-YELLOW -> state, timer and outputs frozen; the remaining yellow resumes when tick returns.
6. Assert rst for 1 cycle mid-GREEN of phase2 with ped_pending=1 -> light all RED and walk=0 without waiting for a clk edge, busy_ped=0; on release the first GREEN is phase0.
